// File: rtl/tx_frame_pkg.sv
// Shared definitions for the transmit frame scheduler and the receive-side
// frame sync: field states, default preamble/sync patterns, length helpers.
package tx_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_SYNC = 3'd2,
    ST_PAY  = 3'd3,
    ST_TAIL = 3'd4,
    ST_PAD  = 3'd5,
    ST_GAP  = 3'd6
  } frame_state_t;

  localparam logic [7:0]  PRE_PAT_DEFAULT   = 8'h55;
  localparam logic [15:0] SYNC_WORD_DEFAULT = 16'h2DD4;
  localparam int          PRE_LEN           = 8;
  localparam int          SYNC_LEN          = 16;

  // Bits in a frame before block padding.
  function automatic int raw_bits(input int payload_bytes, input int tail_bits);
    return PRE_LEN + SYNC_LEN + 8 * payload_bytes + tail_bits;
  endfunction

  // Zero bits needed to round a raw frame up to a whole interleaver block.
  function automatic int pad_bits(input int raw, input int block_bits);
    return (block_bits - (raw % block_bits)) % block_bits;
  endfunction

  // Longest field (or gap) the shared bit counter has to cover.
  function automatic int max_field(input int pay_len, input int tail_len,
                                   input int pad_len, input int gap_len);
    int m;
    m = SYNC_LEN;
    if (pay_len > m)  m = pay_len;
    if (tail_len > m) m = tail_len;
    if (pad_len > m)  m = pad_len;
    if (gap_len > m)  m = gap_len;
    return m;
  endfunction

endpackage

// File: rtl/tx_frame_ctrl_byte_serializer.sv
// Payload byte path: one-byte hold register fed by the byte source, 8-bit
// MSB-first shift register feeding the bit stream, zero substitution when
// the hold register is empty at a byte boundary.
module byte_serializer
  import tx_frame_pkg::*;
#(
  parameter int PAYLOAD_BYTES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  input  logic       accept_en,   // controller state allows taking bytes
  input  logic       load,        // byte boundary: move hold -> shift
  input  logic       shift,       // a payload bit was consumed
  input  logic       clear,       // frame finished: restart fetched count
  output logic       byte_ready,
  output logic       ser_bit,
  output logic       underrun
);

  logic [7:0] hold_q;
  logic       hold_full_q;
  logic [7:0] shift_q;
  logic [7:0] fetched_q;
  logic       underrun_q;
  logic [8:0] committed;
  logic       accept;

  // Handshake: valid/ready are independent; a byte moves when both are high
  // at a rising edge. Ready never takes a byte beyond this frame's quota.
  always_comb begin
    committed  = {1'b0, fetched_q} + {8'b0, hold_full_q};
    byte_ready = !rst && accept_en && !hold_full_q &&
                 (committed < 9'(PAYLOAD_BYTES));
    accept     = byte_valid && byte_ready;
  end

  // Hold register: a new byte wins over the same-cycle unload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
    end else if (accept) begin
      hold_q      <= byte_in;
      hold_full_q <= 1'b1;
    end else if (load) begin
      hold_full_q <= 1'b0;
    end
  end

  // Shift register, fetched-byte count and underrun pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q    <= 8'h00;
      fetched_q  <= 8'h00;
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= 1'b0;
      if (load) begin
        shift_q    <= hold_full_q ? hold_q : 8'h00;
        underrun_q <= !hold_full_q;
        fetched_q  <= fetched_q + 8'd1;
      end else if (shift) begin
        shift_q <= {shift_q[6:0], 1'b0};
      end
      if (clear) fetched_q <= 8'h00;
    end
  end

  assign ser_bit  = shift_q[7];
  assign underrun = underrun_q;

endmodule

// File: rtl/tx_frame_ctrl.sv
// Transmit frame scheduler: preamble, sync word, payload, encoder tail and
// block padding released one bit per encoder strobe, then an idle gap.
module tx_frame_ctrl
  import tx_frame_pkg::*;
#(
  parameter logic [7:0]  PRE_PAT       = PRE_PAT_DEFAULT,
  parameter logic [15:0] SYNC_WORD     = SYNC_WORD_DEFAULT,
  parameter int          PAYLOAD_BYTES = 4,
  parameter int          TAIL_BITS     = 2,
  parameter int          BLOCK_BITS    = 64,
  parameter int          GAP_CYCLES    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  input  logic       bit_ready,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       frame_start,
  output logic       busy,
  output logic       underrun,
  output logic [2:0] dbg_state
);

  localparam int RAW     = raw_bits(PAYLOAD_BYTES, TAIL_BITS);
  localparam int PAD     = pad_bits(RAW, BLOCK_BITS);
  localparam int PAY_LEN = 8 * PAYLOAD_BYTES;
  localparam int MAX_LEN = max_field(PAY_LEN, TAIL_BITS, PAD, GAP_CYCLES);
  localparam int CW      = $clog2(MAX_LEN + 1);

  localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_LEN - 1);
  localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_LEN - 1);
  localparam logic [CW-1:0] PAY_LAST  = CW'(PAY_LEN - 1);
  localparam logic [CW-1:0] TAIL_LAST = CW'(TAIL_BITS - 1);
  localparam logic [CW-1:0] PAD_LAST  = CW'(PAD - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

  frame_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          start_q, start_d;
  logic          accept_en, load, shift, ser_bit;
  logic [2:0]    pre_idx;
  logic [3:0]    sync_idx;
  frame_state_t  after_pay, after_tail;

  byte_serializer #(
    .PAYLOAD_BYTES (PAYLOAD_BYTES)
  ) u_ser (
    .clk        (clk),
    .rst        (reset),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .accept_en  (accept_en),
    .load       (load),
    .shift      (shift),
    .clear      (state_q == ST_GAP),
    .byte_ready (byte_ready),
    .ser_bit    (ser_bit),
    .underrun   (underrun)
  );

  // State, field bit counter and frame_start pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
    end
  end

  // Field sequencing: each consumed bit advances the counter, the last bit
  // of a field moves to the next one; empty tail/pad fields are skipped.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    start_d    = 1'b0;
    accept_en  = 1'b0;
    load       = 1'b0;
    shift      = 1'b0;
    bit_valid  = 1'b0;
    bit_out    = 1'b0;
    pre_idx    = 3'd7 - cnt_q[2:0];
    sync_idx   = 4'd15 - cnt_q[3:0];
    after_tail = (PAD > 0) ? ST_PAD : ST_GAP;
    after_pay  = (TAIL_BITS > 0) ? ST_TAIL : after_tail;
    unique case (state_q)
      ST_IDLE: begin
        accept_en = 1'b1;
        if (byte_valid && byte_ready) begin
          state_d = ST_PRE;
          cnt_d   = '0;
          start_d = 1'b1;
        end
      end
      ST_PRE: begin
        accept_en = 1'b1;
        bit_valid = 1'b1;
        bit_out   = PRE_PAT[pre_idx];
        if (bit_ready) begin
          if (cnt_q == PRE_LAST) begin
            state_d = ST_SYNC;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_SYNC: begin
        accept_en = 1'b1;
        bit_valid = 1'b1;
        bit_out   = SYNC_WORD[sync_idx];
        if (bit_ready) begin
          if (cnt_q == SYNC_LAST) begin
            state_d = ST_PAY;
            cnt_d   = '0;
            load    = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_PAY: begin
        accept_en = 1'b1;
        bit_valid = 1'b1;
        bit_out   = ser_bit;
        if (bit_ready) begin
          if (cnt_q == PAY_LAST) begin
            state_d = after_pay;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q[2:0] == 3'd7) load = 1'b1;
            else                    shift = 1'b1;
          end
        end
      end
      ST_TAIL: begin
        bit_valid = 1'b1;
        if (bit_ready) begin
          if (cnt_q == TAIL_LAST) begin
            state_d = after_tail;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_PAD: begin
        bit_valid = 1'b1;
        if (bit_ready) begin
          if (cnt_q == PAD_LAST) begin
            state_d = ST_GAP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign frame_start = start_q;
  assign busy        = (state_q != ST_IDLE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// Bench for tx_frame_ctrl: directed and randomized byte/strobe patterns
// compared with a frame-level reference built from the byte list.
module tb_tx_frame_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic       bit_ready;
  logic       bit_out;
  logic       bit_valid;
  logic       frame_start;
  logic       busy;
  logic       underrun;
  logic [2:0] dbg_state;

  tx_frame_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .bit_ready   (bit_ready),
    .bit_out     (bit_out),
    .bit_valid   (bit_valid),
    .frame_start (frame_start),
    .busy        (busy),
    .underrun    (underrun),
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Scoreboard state
  logic [7:0]  src_q[$];    // bytes still to be offered by the source
  logic [7:0]  model_q[$];  // every byte offered in this test, in order
  logic [63:0] cap_q[$];    // completed frames captured from bit_out
  int          ur_q[$];     // underrun positions: frame*64 + bits so far
  int          gap_q[$];    // busy && !bit_valid cycles per busy period
  int          idle_q[$];   // !busy cycles between busy periods
  logic [63:0] cur_frame;
  int          cur_bits, fs_cnt, gap_run, idle_run, br_mode;
  logic        stall_prev, prev_bit, prev_busy, seen_busy, br_toggle;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic begin_test();
    model_q.delete(); cap_q.delete(); ur_q.delete(); gap_q.delete(); idle_q.delete();
    cur_frame = '0; cur_bits = 0; fs_cnt = 0; gap_run = 0; idle_run = 0;
    stall_prev = 1'b0; prev_busy = 1'b0; seen_busy = 1'b0;
  endtask

  task automatic offer(input logic [7:0] b);
    src_q.push_back(b);
    model_q.push_back(b);
  endtask

  // One clock: observe at the falling edge, drive just after the rising edge.
  task automatic tick();
    logic acc;
    @(negedge clk);
    if (stall_prev) chk("stall_hold", {bit_valid, bit_out}, {1'b1, prev_bit});
    if (busy && (!bit_valid || cur_bits >= 56)) chk("ready_closed", byte_ready, 1'b0);
    if (frame_start) fs_cnt++;
    if (underrun) ur_q.push_back(cap_q.size() * 64 + cur_bits);
    if (bit_valid && bit_ready) begin
      cur_frame = {cur_frame[62:0], bit_out};
      cur_bits++;
      if (cur_bits == 64) begin
        cap_q.push_back(cur_frame);
        cur_bits = 0;
      end
    end
    if (busy && !bit_valid) gap_run++;
    if (!busy) idle_run++;
    if (prev_busy && !busy) begin
      gap_q.push_back(gap_run);
      gap_run = 0;
    end
    if (!prev_busy && busy) begin
      if (seen_busy) idle_q.push_back(idle_run);
      seen_busy = 1'b1;
      idle_run = 0;
    end
    prev_busy  = busy;
    stall_prev = bit_valid && !bit_ready;
    prev_bit   = bit_out;
    acc        = byte_valid && byte_ready;
    @(posedge clk);
    #1;
    if (acc) void'(src_q.pop_front());
    byte_valid = (src_q.size() > 0);
    byte_in    = (src_q.size() > 0) ? src_q[0] : 8'h00;
    br_toggle  = ~br_toggle;
    case (br_mode)
      0:       bit_ready = 1'b1;
      1:       bit_ready = br_toggle;
      default: bit_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  // Run until n frames are captured and the controller is back in idle.
  task automatic wait_frames(input string name, input int n);
    int c;
    c = 0;
    while ((cap_q.size() < n || busy) && c < 4000) begin
      tick();
      c++;
    end
    chk($sformatf("%s.in_time", name), (c < 4000), 1'b1);
    tick();
    tick();
  endtask

  // Reference: frame f carries bytes 4f..4f+3 of the offered list, missing
  // ones become 0x00 with an underrun at that byte's first payload bit.
  task automatic check_test(input string name, input int nframes);
    logic [31:0] payload;
    int          idx;
    int          exp_ur[$];
    chk($sformatf("%s.frames", name), cap_q.size(), nframes);
    chk($sformatf("%s.frame_start", name), fs_cnt, nframes);
    for (int f = 0; f < nframes; f++) begin
      payload = '0;
      for (int i = 0; i < 4; i++) begin
        idx = 4 * f + i;
        if (idx < model_q.size()) payload[31 - 8 * i -: 8] = model_q[idx];
        else exp_ur.push_back(f * 64 + 24 + 8 * i);
      end
      if (f < cap_q.size())
        chk($sformatf("%s.bits%0d", name, f), cap_q[f], {8'h55, 16'h2DD4, payload, 8'h00});
    end
    chk($sformatf("%s.underruns", name), ur_q.size(), exp_ur.size());
    for (int i = 0; i < ur_q.size() && i < exp_ur.size(); i++)
      chk($sformatf("%s.ur_pos%0d", name, i), ur_q[i], exp_ur[i]);
    chk($sformatf("%s.gaps", name), gap_q.size(), nframes);
    foreach (gap_q[i]) chk($sformatf("%s.gap%0d", name, i), gap_q[i], 16);
    chk($sformatf("%s.idles", name), idle_q.size(), nframes - 1);
    foreach (idle_q[i]) chk($sformatf("%s.idle%0d", name, i), (idle_q[i] >= 1), 1'b1);
  endtask

  initial begin
    int k, c;
    reset = 1'b1; byte_in = 8'h00; byte_valid = 1'b0; bit_ready = 1'b0;
    br_mode = 0; br_toggle = 1'b0;
    begin_test();
    repeat (3) tick();
    chk("reset_outputs", {byte_ready, bit_out, bit_valid, frame_start, busy, underrun}, 6'b0);
    reset = 1'b0;
    tick();
    chk("idle_outputs", {byte_ready, bit_valid, busy, frame_start}, 4'b1000);

    // 1: default frame, strobe always high
    begin_test(); br_mode = 0;
    offer(8'hA5); offer(8'h3C); offer(8'h0F); offer(8'hF0);
    wait_frames("t1", 1);
    check_test("t1", 1);

    // 2: strobe on every other cycle
    begin_test(); br_mode = 1;
    offer(8'hA5); offer(8'h3C); offer(8'h0F); offer(8'hF0);
    wait_frames("t2", 1);
    check_test("t2", 1);

    // 3: two bytes only, bytes 3 and 4 substituted
    begin_test(); br_mode = 0;
    offer(8'hA5); offer(8'h3C);
    wait_frames("t3", 1);
    check_test("t3", 1);

    // 4: eight bytes back to back, two frames
    begin_test(); br_mode = 0;
    for (int i = 0; i < 8; i++) offer(8'($urandom));
    wait_frames("t4", 2);
    check_test("t4", 2);

    // 5: reset after bit 30, then a clean frame from the preamble
    begin_test(); br_mode = 0;
    for (int i = 0; i < 4; i++) offer(8'($urandom));
    c = 0;
    while (cur_bits < 31 && c < 500) begin
      tick();
      c++;
    end
    chk("t5.reached_bit30", (cur_bits >= 31), 1'b1);
    #2 reset = 1'b1;
    #1 chk("t5.async_reset", {byte_ready, bit_out, bit_valid, frame_start, busy, underrun}, 6'b0);
    src_q.delete();
    stall_prev = 1'b0; prev_busy = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    begin_test();
    for (int i = 0; i < 4; i++) offer(8'($urandom));
    wait_frames("t5", 1);
    check_test("t5", 1);

    // 6: byte 77 waits through tail/pad/gap and opens the next frame
    begin_test(); br_mode = 0;
    for (int i = 0; i < 4; i++) offer(8'($urandom));
    offer(8'h77);
    for (int i = 0; i < 3; i++) offer(8'($urandom));
    wait_frames("t6", 2);
    check_test("t6", 2);

    // 7: random byte count and random strobe
    for (int r = 0; r < 3; r++) begin
      begin_test(); br_mode = 2;
      k = $urandom_range(5, 12);
      for (int i = 0; i < k; i++) offer(8'($urandom));
      wait_frames($sformatf("t7_%0d", r), (k + 3) / 4);
      check_test($sformatf("t7_%0d", r), (k + 3) / 4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
